// File: rtl/compute_slot_responder_if.sv
// Dispatch / completion handshake between the HDU and the compute responder.
// The master side (HDU) issues dispatch strobes and receives completions;
// the slave side (compute responder) does the reverse. There is no ready:
// neither side can stall the other.
interface compute_slot_responder_if #(
  parameter int SLOT_W = 2
);
  logic              dispatch_valid;
  logic [SLOT_W-1:0] dispatch_slot;
  logic              compute_done_valid;
  logic [SLOT_W-1:0] compute_done_slot;

  modport master (
    output dispatch_valid,
    output dispatch_slot,
    input  compute_done_valid,
    input  compute_done_slot
  );

  modport slave (
    input  dispatch_valid,
    input  dispatch_slot,
    output compute_done_valid,
    output compute_done_slot
  );
endinterface

// File: rtl/compute_slot_responder.sv
// Compute-side responder for the HDU dispatch interface. Each slot runs an
// IDLE -> RUN -> PEND -> IDLE lifecycle: a dispatch loads a latency counter,
// the slot becomes pending when the counter expires, and a round-robin
// arbiter frees one pending slot per cycle as a one-cycle completion strobe.
// Optional build macro COMPUTE_SLOT_RESP_JITTER_EN adds a 16-bit LFSR that
// perturbs each job's latency by 0..15 cycles.
module compute_slot_responder #(
  parameter int MAX_SLOTS   = 4,
  parameter int SLOT_W      = (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1,
  parameter int LAT_W       = 8,
  parameter int DEFAULT_LAT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  compute_slot_responder_if.slave   bus,
  input  logic [LAT_W-1:0]          cfg_lat,
  input  logic                      cfg_lat_wr,
  input  logic                      done_hold,
  output logic [MAX_SLOTS-1:0]      busy_mask,
  output logic                      err_dup_dispatch,
  output logic [31:0]               stat_completed,
  output logic [31:0]               stat_dup
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } slot_state_t;

  slot_state_t       state [MAX_SLOTS];
  logic [LAT_W-1:0]  cnt   [MAX_SLOTS];
  logic [LAT_W-1:0]  lat_reg;
  logic [SLOT_W-1:0] ptr;

  logic              grant_vld;
  logic [SLOT_W-1:0] grant_idx;
  logic [SLOT_W-1:0] cand;
  logic              slot_in_range;
  logic              slot_idle;
  logic              accept;
  logic              dup;
  logic [LAT_W-1:0]  lat_eff;

  // Saturate a widened latency sum to the counter range; zero becomes one
  // so every job spends at least one cycle in RUN.
  function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W:0] sum);
    if (sum[LAT_W])
      return '1;
    else if (sum[LAT_W-1:0] == '0)
      return LAT_W'(1);
    else
      return sum[LAT_W-1:0];
  endfunction

  // Round-robin successor of the granted slot.
  function automatic logic [SLOT_W-1:0] next_ptr(input logic [SLOT_W-1:0] g);
    if (g == SLOT_W'(MAX_SLOTS - 1))
      return '0;
    else
      return g + SLOT_W'(1);
  endfunction

  // Dispatch decode: out-of-range or non-idle targets are duplicates.
  always_comb begin
    slot_in_range = 1'b0;
    slot_idle     = 1'b0;
    for (int s = 0; s < MAX_SLOTS; s++) begin
      if (bus.dispatch_slot == SLOT_W'(s)) begin
        slot_in_range = 1'b1;
        slot_idle     = (state[s] == S_IDLE);
      end
    end
    accept = bus.dispatch_valid && slot_in_range && slot_idle;
    dup    = bus.dispatch_valid && !accept;
  end

  // Round-robin search over pending slots starting at the pointer.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < MAX_SLOTS; k++) begin
      cand = SLOT_W'((int'(ptr) + k) % MAX_SLOTS);
      if (!grant_vld && state[cand] == S_PEND) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (done_hold)
      grant_vld = 1'b0;
  end

`ifdef COMPUTE_SLOT_RESP_JITTER_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR (taps 16,14,13,11), stepped once per accepted dispatch.
  always_ff @(posedge clk) begin
    if (rst)
      lfsr <= 16'hACE1;
    else if (accept)
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign lat_eff = clamp_lat({1'b0, lat_reg} + (LAT_W + 1)'(lfsr[3:0]));
`else
  assign lat_eff = clamp_lat({1'b0, lat_reg});
`endif

  // Per-slot lifecycle FSMs with the registered busy mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < MAX_SLOTS; s++)
        state[s] <= S_IDLE;
      busy_mask <= '0;
    end else begin
      for (int s = 0; s < MAX_SLOTS; s++) begin
        case (state[s])
          S_IDLE: begin
            if (accept && bus.dispatch_slot == SLOT_W'(s)) begin
              state[s]     <= S_RUN;
              cnt[s]       <= lat_eff;
              busy_mask[s] <= 1'b1;
            end
          end
          S_RUN: begin
            cnt[s] <= cnt[s] - LAT_W'(1);
            if (cnt[s] == LAT_W'(1))
              state[s] <= S_PEND;
          end
          S_PEND: begin
            if (grant_vld && grant_idx == SLOT_W'(s)) begin
              state[s]     <= S_IDLE;
              busy_mask[s] <= 1'b0;
            end
          end
          default: state[s] <= S_IDLE;
        endcase
      end
    end
  end

  // Latency register, arbiter pointer, completion strobe, error pulse, stats.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_reg                <= LAT_W'(DEFAULT_LAT);
      ptr                    <= '0;
      bus.compute_done_valid <= 1'b0;
      bus.compute_done_slot  <= '0;
      err_dup_dispatch       <= 1'b0;
      stat_completed         <= '0;
      stat_dup               <= '0;
    end else begin
      if (cfg_lat_wr)
        lat_reg <= cfg_lat;
      bus.compute_done_valid <= grant_vld;
      if (grant_vld) begin
        bus.compute_done_slot <= grant_idx;
        ptr                   <= next_ptr(grant_idx);
        stat_completed        <= stat_completed + 32'd1;
      end
      err_dup_dispatch <= dup;
      if (dup)
        stat_dup <= stat_dup + 32'd1;
    end
  end

endmodule

// File: tb/tb_compute_slot_responder.sv
// Bench for compute_slot_responder: a directed vector table, hand-written
// corner-case sequences and randomized traffic, all checked every cycle
// against a time-stamp reference model (each busy slot remembers the edge at
// which it becomes pending).
module tb_compute_slot_responder;
  localparam int MAX_SLOTS = 4;
  localparam int SLOT_W    = 2;
  localparam int LAT_W     = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [LAT_W-1:0]     cfg_lat;
  logic                 cfg_lat_wr;
  logic                 done_hold;
  logic [MAX_SLOTS-1:0] busy_mask;
  logic                 err_dup_dispatch;
  logic [31:0]          stat_completed;
  logic [31:0]          stat_dup;

  compute_slot_responder_if #(.SLOT_W(SLOT_W)) bus ();

  compute_slot_responder #(
    .MAX_SLOTS(MAX_SLOTS), .SLOT_W(SLOT_W), .LAT_W(LAT_W), .DEFAULT_LAT(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cfg_lat(cfg_lat), .cfg_lat_wr(cfg_lat_wr), .done_hold(done_hold),
    .busy_mask(busy_mask), .err_dup_dispatch(err_dup_dispatch),
    .stat_completed(stat_completed), .stat_dup(stat_dup)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int          edge_n = 0;
  bit          m_busy    [MAX_SLOTS];
  int          m_pend_at [MAX_SLOTS];
  int          m_ptr;
  int          m_lat;
  bit [31:0]   m_comp;
  bit [31:0]   m_dup;
  bit          m_done_v;
  int          m_done_s;
  bit          m_err;

  int got_q[$];
  int done_edge;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, edge_n - 1, act, exp);
    end
  endtask

  // One clock edge of the behavioural model, using pre-edge state throughout.
  task automatic model_edge(input bit r, input bit dv, input int ds,
                            input bit wr, input int cl, input bit hold);
    int gi;
    int s;
    bit acc;
    int lval;
    m_done_v = 1'b0;
    m_err    = 1'b0;
    if (r) begin
      for (int i = 0; i < MAX_SLOTS; i++) m_busy[i] = 1'b0;
      m_ptr = 0; m_lat = 16; m_comp = 0; m_dup = 0; m_done_s = 0;
    end else begin
      gi = -1;
      if (!hold) begin
        for (int k = 0; k < MAX_SLOTS; k++) begin
          s = (m_ptr + k) % MAX_SLOTS;
          if (gi < 0 && m_busy[s] && edge_n > m_pend_at[s]) gi = s;
        end
      end
      acc = 1'b0;
      if (dv) begin
        if (ds >= MAX_SLOTS || m_busy[ds]) begin
          m_err = 1'b1;
          m_dup++;
        end else begin
          acc = 1'b1;
        end
      end
      if (gi >= 0) begin
        m_busy[gi] = 1'b0;
        m_done_v   = 1'b1;
        m_done_s   = gi;
        m_comp++;
        m_ptr = (gi + 1) % MAX_SLOTS;
      end
      if (acc) begin
        lval          = (m_lat == 0) ? 1 : m_lat;
        m_busy[ds]    = 1'b1;
        m_pend_at[ds] = edge_n + lval;
      end
      if (wr) m_lat = cl;
    end
    edge_n++;
  endtask

  function automatic logic [MAX_SLOTS-1:0] m_busy_vec();
    logic [MAX_SLOTS-1:0] v;
    for (int i = 0; i < MAX_SLOTS; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Drive one cycle, advance the model, and compare all outputs 1ns after the edge.
  task automatic step(input bit r, input bit dv, input int ds,
                      input bit wr, input int cl, input bit hold);
    rst                = r;
    bus.dispatch_valid = dv;
    bus.dispatch_slot  = SLOT_W'(ds);
    cfg_lat_wr         = wr;
    cfg_lat            = LAT_W'(cl);
    done_hold          = hold;
    @(posedge clk);
    model_edge(r, dv, ds, wr, cl, hold);
    #1;
    chk("done_valid", 32'(bus.compute_done_valid), 32'(m_done_v));
    if (m_done_v) chk("done_slot", 32'(bus.compute_done_slot), 32'(m_done_s));
    chk("busy_mask", 32'(busy_mask), 32'(m_busy_vec()));
    chk("err_dup", 32'(err_dup_dispatch), 32'(m_err));
    chk("stat_completed", stat_completed, m_comp);
    chk("stat_dup", stat_dup, m_dup);
    if (bus.compute_done_valid === 1'b1) begin
      got_q.push_back(int'(bus.compute_done_slot));
      done_edge = edge_n - 1;
    end
  endtask

  task automatic idle(input int n, input bit hold);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, hold);
  endtask

  typedef struct {
    bit       dv;
    int       ds;
    bit       wr;
    int       cl;
    bit       exp_v;
    int       exp_s;
    bit [3:0] exp_busy;
    int       exp_comp;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int t0;

    // Latency 4, dispatch slot 2: done after the 5th edge past dispatch.
    tbl[0] = '{0, 0, 1, 4, 0, 0, 4'b0000, 0};
    tbl[1] = '{1, 2, 0, 0, 0, 0, 4'b0100, 0};
    tbl[2] = '{0, 0, 0, 0, 0, 0, 4'b0100, 0};
    tbl[3] = '{0, 0, 0, 0, 0, 0, 4'b0100, 0};
    tbl[4] = '{0, 0, 0, 0, 0, 0, 4'b0100, 0};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 4'b0100, 0};
    tbl[6] = '{0, 0, 0, 0, 1, 2, 4'b0000, 1};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 4'b0000, 1};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 4'b0000, 1};

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_done_valid", 32'(bus.compute_done_valid), 32'd0);
    chk("reset_busy", 32'(busy_mask), 32'd0);
    chk("reset_stat_completed", stat_completed, 32'd0);

    // Vector table
    for (int i = 0; i < 9; i++) begin
      step(0, tbl[i].dv, tbl[i].ds, tbl[i].wr, tbl[i].cl, 0);
      chk("tbl_done_valid", 32'(bus.compute_done_valid), 32'(tbl[i].exp_v));
      if (tbl[i].exp_v) chk("tbl_done_slot", 32'(bus.compute_done_slot), 32'(tbl[i].exp_s));
      chk("tbl_busy", 32'(busy_mask), 32'(tbl[i].exp_busy));
      chk("tbl_completed", stat_completed, 32'(tbl[i].exp_comp));
    end

    // Hold for 10 cycles with all four slots pending, then release in order.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 0);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 1);
    step(0, 1, 2, 0, 0, 1);
    step(0, 1, 3, 0, 0, 1);
    got_q.delete();
    idle(6, 1);
    chk("hold_no_done", 32'(got_q.size()), 32'd0);
    chk("hold_busy", 32'(busy_mask), 32'hF);
    idle(5, 0);
    chk("release_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk("release_order", 32'(got_q[i]), 32'(i));
    chk("release_completed", stat_completed, 32'd4);

    // Move pointer to 2, then slots 0 and 3 pending at release: 3 before 0.
    step(0, 1, 1, 0, 0, 0);
    idle(5, 0);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 3, 0, 0, 1);
    idle(5, 1);
    got_q.delete();
    idle(3, 0);
    chk("wrap_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      chk("wrap_first", 32'(got_q[0]), 32'd3);
      chk("wrap_second", 32'(got_q[1]), 32'd0);
    end

    // Duplicate dispatch to slot 1 while running, latency 10.
    step(0, 0, 0, 1, 10, 0);
    got_q.delete();
    t0 = edge_n;
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    chk("dup_pulse", 32'(err_dup_dispatch), 32'd1);
    step(0, 0, 0, 0, 0, 0);
    chk("dup_pulse_one_cycle", 32'(err_dup_dispatch), 32'd0);
    idle(10, 0);
    chk("dup_single_completion", 32'(got_q.size()), 32'd1);
    chk("dup_completion_time", 32'(done_edge), 32'(t0 + 11));
    chk("dup_count", stat_dup, 32'd1);

    // Dispatch on the same edge as the grant, then re-dispatch on the next one.
    step(0, 0, 0, 1, 2, 0);
    t0 = edge_n;
    step(0, 1, 0, 0, 0, 0);
    idle(2, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("same_edge_grant", 32'(bus.compute_done_valid), 32'd1);
    chk("same_edge_dup", 32'(err_dup_dispatch), 32'd1);
    step(0, 1, 0, 0, 0, 0);
    chk("redispatch_ok", 32'(err_dup_dispatch), 32'd0);
    idle(4, 0);
    chk("redispatch_time", 32'(done_edge), 32'(t0 + 4 + 3));

    // Latency 0 behaves as 1; then reset while three slots run.
    step(0, 0, 0, 1, 0, 0);
    t0 = edge_n;
    step(0, 1, 2, 0, 0, 0);
    idle(3, 0);
    chk("lat0_time", 32'(done_edge), 32'(t0 + 2));
    step(0, 0, 0, 1, 10, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 3, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    got_q.delete();
    idle(15, 0);
    chk("reset_drop_jobs", 32'(got_q.size()), 32'd0);
    chk("reset_drop_busy", 32'(busy_mask), 32'd0);
    t0 = edge_n;
    step(0, 1, 0, 0, 0, 0);
    idle(18, 0);
    chk("reset_default_lat", 32'(done_edge), 32'(t0 + 17));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit r, dv, wr, hold;
      int ds, cl;
      r    = ($urandom_range(0, 299) == 0);
      dv   = ($urandom_range(0, 1) == 1);
      ds   = $urandom_range(0, MAX_SLOTS - 1);
      wr   = ($urandom_range(0, 19) == 0);
      cl   = $urandom_range(0, 6);
      hold = ($urandom_range(0, 3) == 0);
      step(r, dv, ds, wr, cl, hold);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
